// File: rtl/reg_file_pkg.sv
// Shared sizing constants and types for the 32 x 64-bit architectural register file.
package reg_file_pkg;
   localparam int unsigned NREGS    = 32;
   localparam int unsigned WIDTH    = 64;
   localparam int unsigned ZERO_REG = 31;
   localparam int unsigned ADDR_W   = $clog2(NREGS);

   typedef logic [ADDR_W-1:0] reg_addr_t;
   typedef logic [WIDTH-1:0]  word_t;

   localparam reg_addr_t ZERO_ADDR = ADDR_W'(ZERO_REG);
endpackage

// File: rtl/reg_file_if.sv
// Write-back, claim and operand-fetch signals between the pipeline and the register file.
interface reg_file_if;
   import reg_file_pkg::*;

   logic      wr_en;
   reg_addr_t wr_addr;
   word_t     wr_data;
   logic      claim_en;
   reg_addr_t claim_addr;
   reg_addr_t rd_addr_a;
   reg_addr_t rd_addr_b;
   word_t     rd_data_a;
   word_t     rd_data_b;
   logic      busy_a;
   logic      busy_b;

   modport master (
      output wr_en, wr_addr, wr_data, claim_en, claim_addr, rd_addr_a, rd_addr_b,
      input  rd_data_a, rd_data_b, busy_a, busy_b
   );

   modport slave (
      input  wr_en, wr_addr, wr_data, claim_en, claim_addr, rd_addr_a, rd_addr_b,
      output rd_data_a, rd_data_b, busy_a, busy_b
   );
endinterface

// File: rtl/reg_word.sv
// One architectural register: load-enable flop bank with asynchronous active-low clear.
module reg_word
   import reg_file_pkg::*;
(
   input  logic  clk,
   input  logic  rst_n,
   input  logic  en,
   input  word_t d,
   output word_t q
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (en) begin
         q <= d;
      end
   end

endmodule

// File: rtl/reg_file.sv
// Register file with zero register, pending scoreboard and write-to-read bypass on both ports.
module reg_file
   import reg_file_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   reg_file_if.slave   bus
);

   localparam int unsigned NSTORE = NREGS - 1;

   word_t             regs_q [NREGS];
   logic [NSTORE-1:0] we;
   logic [NSTORE-1:0] claim_hit;
   logic [NSTORE-1:0] pending;
   logic [NREGS-1:0]  pend_all;
   logic              byp_a;
   logic              byp_b;

   // Decode addresses to one-hot strobes; the zero register never matches.
   for (genvar i = 0; i < NSTORE; i++) begin : g_word
      assign we[i]        = bus.wr_en    && (bus.wr_addr    == ADDR_W'(i));
      assign claim_hit[i] = bus.claim_en && (bus.claim_addr == ADDR_W'(i));

      reg_word u_word (
         .clk   (clk),
         .rst_n (reset),
         .en    (we[i]),
         .d     (bus.wr_data),
         .q     (regs_q[i])
      );
   end

   assign regs_q[NREGS-1] = '0;

   // A claim on the same edge as a write wins: the new producer still owns the register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pending <= '0;
      end else begin
         pending <= (pending & ~we) | claim_hit;
      end
   end

   assign pend_all = {1'b0, pending};
   assign byp_a    = bus.wr_en && (bus.wr_addr == bus.rd_addr_a);
   assign byp_b    = bus.wr_en && (bus.wr_addr == bus.rd_addr_b);

   always_comb begin
      bus.rd_data_a = '0;
      bus.busy_a    = 1'b0;
      if (bus.rd_addr_a != ZERO_ADDR) begin
         if (byp_a) begin
            bus.rd_data_a = bus.wr_data;
         end else begin
            bus.rd_data_a = regs_q[bus.rd_addr_a];
            bus.busy_a    = pend_all[bus.rd_addr_a];
         end
      end
   end

   always_comb begin
      bus.rd_data_b = '0;
      bus.busy_b    = 1'b0;
      if (bus.rd_addr_b != ZERO_ADDR) begin
         if (byp_b) begin
            bus.rd_data_b = bus.wr_data;
         end else begin
            bus.rd_data_b = regs_q[bus.rd_addr_b];
            bus.busy_b    = pend_all[bus.rd_addr_b];
         end
      end
   end

endmodule

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file: reset, bypass, zero register, scoreboard and full sweep.
module tb_reg_file;
   import reg_file_pkg::*;

   logic clk;
   logic reset;
   int   total;
   int   bad;

   reg_file_if bus ();

   reg_file dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      total = 0;
      bad   = 0;
      reset          = 1'b0;
      bus.wr_en      = 1'b0;
      bus.wr_addr    = '0;
      bus.wr_data    = '0;
      bus.claim_en   = 1'b0;
      bus.claim_addr = '0;
      bus.rd_addr_a  = 5'd5;
      bus.rd_addr_b  = 5'd30;
      #3;
      chk("rst_data_a", bus.rd_data_a, 64'd0);
      chk("rst_data_b", bus.rd_data_b, 64'd0);
      chk("rst_busy_a", 64'(bus.busy_a), 64'd0);
      chk("rst_busy_b", 64'(bus.busy_b), 64'd0);
      #4 reset = 1'b1;

      // Write X5 then pulse reset mid-period: storage clears without a clock.
      tick();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd5; bus.wr_data = 64'hDEAD;
      #1 chk("x5_bypass", bus.rd_data_a, 64'hDEAD);
      tick();
      bus.wr_en = 1'b0;
      #1 chk("x5_stored", bus.rd_data_a, 64'hDEAD);
      #1 reset = 1'b0;
      #1 chk("x5_async_clr", bus.rd_data_a, 64'd0);
      #1 reset = 1'b1;

      // Reset held across an edge discards a write and a claim in flight.
      tick();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd12; bus.wr_data = 64'h55;
      bus.claim_en = 1'b1; bus.claim_addr = 5'd13;
      reset = 1'b0;
      tick();
      bus.wr_en = 1'b0; bus.claim_en = 1'b0;
      reset = 1'b1;
      bus.rd_addr_a = 5'd12; bus.rd_addr_b = 5'd13;
      #1;
      chk("midop_x12", bus.rd_data_a, 64'd0);
      chk("midop_x13_busy", 64'(bus.busy_b), 64'd0);

      // X3 bypass then storage.
      tick();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd3; bus.wr_data = 64'h0123_4567_89AB_CDEF;
      bus.rd_addr_a = 5'd3;
      #1 chk("x3_bypass", bus.rd_data_a, 64'h0123_4567_89AB_CDEF);
      tick();
      bus.wr_en = 1'b0;
      #1 chk("x3_stored", bus.rd_data_a, 64'h0123_4567_89AB_CDEF);

      // X31 ignores writes and claims, never bypasses.
      tick();
      bus.wr_en = 1'b1; bus.wr_addr = 5'd31; bus.wr_data = '1;
      bus.rd_addr_a = 5'd31; bus.rd_addr_b = 5'd31;
      #1;
      chk("x31_byp_a", bus.rd_data_a, 64'd0);
      chk("x31_byp_b", bus.rd_data_b, 64'd0);
      tick();
      bus.wr_en = 1'b0;
      bus.claim_en = 1'b1; bus.claim_addr = 5'd31;
      #1;
      chk("x31_rd_a", bus.rd_data_a, 64'd0);
      chk("x31_rd_b", bus.rd_data_b, 64'd0);
      tick();
      bus.claim_en = 1'b0;
      #1 chk("x31_busy", 64'(bus.busy_a), 64'd0);
      bus.rd_addr_a = 5'd3;
      #1 chk("x3_intact", bus.rd_data_a, 64'h0123_4567_89AB_CDEF);

      // Claim X7, then write-back clears it through the bypass.
      tick();
      bus.claim_en = 1'b1; bus.claim_addr = 5'd7; bus.rd_addr_a = 5'd7;
      #1 chk("x7_claim_cyc", 64'(bus.busy_a), 64'd0);
      tick();
      bus.claim_en = 1'b0;
      #1 chk("x7_busy", 64'(bus.busy_a), 64'd1);
      bus.wr_en = 1'b1; bus.wr_addr = 5'd7; bus.wr_data = 64'd42;
      #1;
      chk("x7_wr_busy", 64'(bus.busy_a), 64'd0);
      chk("x7_wr_data", bus.rd_data_a, 64'd42);
      tick();
      bus.wr_en = 1'b0;
      #1;
      chk("x7_after_busy", 64'(bus.busy_a), 64'd0);
      chk("x7_after_data", bus.rd_data_a, 64'd42);
      tick();
      chk("x7_later_busy", 64'(bus.busy_a), 64'd0);

      // Same-edge claim and write to X9: data lands, pending stays set.
      bus.claim_en = 1'b1; bus.claim_addr = 5'd9;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd9; bus.wr_data = 64'd100;
      bus.rd_addr_a = 5'd9;
      #1 chk("x9_byp_busy", 64'(bus.busy_a), 64'd0);
      tick();
      bus.claim_en = 1'b0; bus.wr_en = 1'b0;
      #1;
      chk("x9_data", bus.rd_data_a, 64'd100);
      chk("x9_busy", 64'(bus.busy_a), 64'd1);

      // Claim X10 and write X11 on the same edge.
      tick();
      bus.claim_en = 1'b1; bus.claim_addr = 5'd10;
      bus.wr_en = 1'b1; bus.wr_addr = 5'd11; bus.wr_data = 64'd5;
      tick();
      bus.claim_en = 1'b0; bus.wr_en = 1'b0;
      bus.rd_addr_a = 5'd10; bus.rd_addr_b = 5'd11;
      #1;
      chk("x10_busy", 64'(bus.busy_a), 64'd1);
      chk("x10_data", bus.rd_data_a, 64'd0);
      chk("x11_busy", 64'(bus.busy_b), 64'd0);
      chk("x11_data", bus.rd_data_b, 64'd5);

      // Fill X1..X30 with i*0x1111; writes also clear the X9/X10 claims.
      for (int i = 1; i <= 30; i++) begin
         tick();
         bus.wr_en = 1'b1; bus.wr_addr = 5'(i); bus.wr_data = 64'(i) * 64'h1111;
      end
      tick();
      bus.wr_en = 1'b0;
      for (int a = 1; a <= 30; a++) begin
         bus.rd_addr_a = 5'(a);
         bus.rd_addr_b = 5'(31 - a);
         #1;
         chk("sweep_a", bus.rd_data_a, 64'(a) * 64'h1111);
         chk("sweep_b", bus.rd_data_b, 64'(31 - a) * 64'h1111);
         chk("sweep_busy_a", 64'(bus.busy_a), 64'd0);
         bus.rd_addr_b = 5'(a);
         #1;
         chk("same_addr_a", bus.rd_data_a, 64'(a) * 64'h1111);
         chk("same_addr_b", bus.rd_data_b, 64'(a) * 64'h1111);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
